// File: rtl/usadd_pkg.sv
// ============================================================================
// Module   : usadd_pkg
// Brief    : Shared state encoding and width helpers for the uSADD emitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package usadd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Accumulator must hold acc + count, i.e. up to 2*NINPUT-1.
  function automatic int accW(input int nInput);
    return $clog2(2 * nInput);
  endfunction

  function automatic int onesW(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/usadd_scale_acc.sv
// ============================================================================
// Module   : usadd_scale_acc
// Brief    : Saturating scaled-add step with residual accumulator register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usadd_scale_acc
  import usadd_pkg::*;
#(
  parameter int BINPUT = 2,
  parameter int NINPUT = 2
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iClr,
  input  logic              iEn,
  input  logic [BINPUT-1:0] iCnt,
  output logic              oEmit,
  output logic              oOver
);

  localparam int ACC_W = accW(NINPUT);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_sat;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_next;
  logic [31:0]      w_cnt32;

  // Compare at 32 bits so NINPUT never gets truncated to the iCnt width.
  assign w_cnt32 = 32'(iCnt);
  assign oOver   = w_cnt32 > 32'(NINPUT);
  assign w_sat   = oOver ? ACC_W'(NINPUT) : ACC_W'(iCnt);
  assign w_sum   = r_acc + w_sat;
  assign oEmit   = w_sum >= ACC_W'(NINPUT);
  assign w_next  = oEmit ? (w_sum - ACC_W'(NINPUT)) : w_sum;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_acc <= '0;
    end else if (iClr) begin
      r_acc <= '0;
    end else if (iEn) begin
      r_acc <= w_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/usadd_unary_emit.sv
// ============================================================================
// Module   : usadd_unary_emit
// Brief    : Re-serialises per-cycle ones-counts into a scaled unary stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usadd_unary_emit
  import usadd_pkg::*;
#(
  parameter int BINPUT = 2,
  parameter int NINPUT = 2,
  parameter int LEN    = 256
) (
  input  logic                     iClk,
  input  logic                     iRstN,
  input  logic                     iStart,
  input  logic                     iValid,
  input  logic [BINPUT-1:0]        iCnt,
  output logic                     oBit,
  output logic                     oValid,
  output logic                     oBusy,
  output logic                     oDone,
  output logic [onesW(LEN)-1:0]    oOnes,
  output logic                     oErr
);

  localparam int ONES_W = onesW(LEN);

  state_t            r_state;
  logic [ONES_W-1:0] r_sampleCnt;
  logic [ONES_W-1:0] r_ones;
  logic              r_bit;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic w_startNew;
  logic w_accept;
  logic w_last;
  logic w_emit;
  logic w_over;

  assign w_startNew = iStart && (r_state != RUN);
  assign w_accept   = iValid && (r_state == RUN);
  assign w_last     = (r_sampleCnt == ONES_W'(LEN - 1));

  usadd_scale_acc #(
    .BINPUT (BINPUT),
    .NINPUT (NINPUT)
  ) u_acc (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iClr  (w_startNew),
    .iEn   (w_accept),
    .iCnt  (iCnt),
    .oEmit (w_emit),
    .oOver (w_over)
  );

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state     <= IDLE;
      r_sampleCnt <= '0;
      r_ones      <= '0;
      r_bit       <= 1'b0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_bit   <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (iStart) begin
            r_state     <= RUN;
            r_busy      <= 1'b1;
            r_sampleCnt <= '0;
            r_ones      <= '0;
            r_err       <= 1'b0;
          end
        end
        RUN: begin
          if (w_accept) begin
            r_valid     <= 1'b1;
            r_bit       <= w_emit;
            r_ones      <= r_ones + ONES_W'(w_emit);
            r_err       <= r_err | w_over;
            r_sampleCnt <= r_sampleCnt + ONES_W'(1);
            // Residual acc is simply dropped here: floor rounding.
            if (w_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign oBit   = r_bit;
  assign oValid = r_valid;
  assign oBusy  = r_busy;
  assign oDone  = r_done;
  assign oOnes  = r_ones;
  assign oErr   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_usadd_unary_emit.sv
// ============================================================================
// Module   : tb_usadd_unary_emit
// Brief    : Directed self-checking bench for usadd_unary_emit (LEN=4, LEN=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usadd_unary_emit;

  logic       iClk = 1'b0;
  logic       iRstN;
  logic       iStart;
  logic       iValid;
  logic [1:0] iCnt;

  logic       oBit, oValid, oBusy, oDone, oErr;
  logic [2:0] oOnes;
  logic       d1Bit, d1Valid, d1Busy, d1Done, d1Err;
  logic [0:0] d1Ones;

  int total = 0;
  int bad   = 0;

  always #5 iClk = ~iClk;

  usadd_unary_emit #(.BINPUT(2), .NINPUT(2), .LEN(4)) dut (
    .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .iValid(iValid), .iCnt(iCnt),
    .oBit(oBit), .oValid(oValid), .oBusy(oBusy), .oDone(oDone),
    .oOnes(oOnes), .oErr(oErr)
  );

  usadd_unary_emit #(.BINPUT(2), .NINPUT(2), .LEN(1)) dut1 (
    .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .iValid(iValid), .iCnt(iCnt),
    .oBit(d1Bit), .oValid(d1Valid), .oBusy(d1Busy), .oDone(d1Done),
    .oOnes(d1Ones), .oErr(d1Err)
  );

  typedef struct {
    int         gap;
    logic [1:0] cnt;
    logic       expBit;
    int         expOnes;
    logic       expErr;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic startStream();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic sendSample(input string name, input logic [1:0] cnt, input logic expBit,
                            input int expOnes, input logic expErr, input logic expDone);
    iValid = 1'b1;
    iCnt   = cnt;
    tick();
    iValid = 1'b0;
    chk({name, ".valid"}, int'(oValid), 1);
    chk({name, ".bit"},   int'(oBit),   int'(expBit));
    chk({name, ".ones"},  int'(oOnes),  expOnes);
    chk({name, ".err"},   int'(oErr),   int'(expErr));
    chk({name, ".done"},  int'(oDone),  int'(expDone));
    chk({name, ".busy"},  int'(oBusy),  int'(!expDone));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // stream A: 1,2,0,1
    tbl[0]  = '{0, 2'd1, 1'b0, 0, 1'b0};
    tbl[1]  = '{0, 2'd2, 1'b1, 1, 1'b0};
    tbl[2]  = '{0, 2'd0, 1'b0, 1, 1'b0};
    tbl[3]  = '{0, 2'd1, 1'b1, 2, 1'b0};
    // stream B: all 2
    tbl[4]  = '{0, 2'd2, 1'b1, 1, 1'b0};
    tbl[5]  = '{0, 2'd2, 1'b1, 2, 1'b0};
    tbl[6]  = '{0, 2'd2, 1'b1, 3, 1'b0};
    tbl[7]  = '{0, 2'd2, 1'b1, 4, 1'b0};
    // stream C: all 0
    tbl[8]  = '{0, 2'd0, 1'b0, 0, 1'b0};
    tbl[9]  = '{0, 2'd0, 1'b0, 0, 1'b0};
    tbl[10] = '{0, 2'd0, 1'b0, 0, 1'b0};
    tbl[11] = '{0, 2'd0, 1'b0, 0, 1'b0};
    // stream D: 1, gap of 3, 1,1,1
    tbl[12] = '{0, 2'd1, 1'b0, 0, 1'b0};
    tbl[13] = '{3, 2'd1, 1'b1, 1, 1'b0};
    tbl[14] = '{0, 2'd1, 1'b0, 1, 1'b0};
    tbl[15] = '{0, 2'd1, 1'b1, 2, 1'b0};
    // stream E: illegal 3 saturates to 2, error sticks
    tbl[16] = '{0, 2'd3, 1'b1, 1, 1'b1};
    tbl[17] = '{0, 2'd0, 1'b0, 1, 1'b1};
    tbl[18] = '{0, 2'd0, 1'b0, 1, 1'b1};
    tbl[19] = '{0, 2'd0, 1'b0, 1, 1'b1};

    iRstN = 1'b0; iStart = 1'b0; iValid = 1'b0; iCnt = 2'd0;
    repeat (2) tick();
    chk("rst.valid", int'(oValid), 0);
    chk("rst.bit",   int'(oBit),   0);
    chk("rst.busy",  int'(oBusy),  0);
    chk("rst.done",  int'(oDone),  0);
    chk("rst.ones",  int'(oOnes),  0);
    chk("rst.err",   int'(oErr),   0);
    iRstN = 1'b1;
    tick();

    // valid while IDLE is ignored
    iValid = 1'b1; iCnt = 2'd2;
    tick();
    iValid = 1'b0;
    chk("idle.valid", int'(oValid), 0);
    chk("idle.busy",  int'(oBusy),  0);

    for (int s = 0; s < 5; s++) begin
      startStream();
      chk($sformatf("s%0d.start.busy", s), int'(oBusy), 1);
      chk($sformatf("s%0d.start.ones", s), int'(oOnes), 0);
      for (int j = 0; j < 4; j++) begin
        for (int g = 0; g < tbl[s*4+j].gap; g++) begin
          tick();
          chk($sformatf("s%0d.gap%0d.valid", s, g), int'(oValid), 0);
          chk($sformatf("s%0d.gap%0d.bit", s, g),   int'(oBit),   0);
        end
        sendSample($sformatf("s%0d.v%0d", s, j), tbl[s*4+j].cnt, tbl[s*4+j].expBit,
                   tbl[s*4+j].expOnes, tbl[s*4+j].expErr, j == 3);
      end
    end

    // DONE holds; valids ignored; error and count persist
    iValid = 1'b1; iCnt = 2'd2;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("hold.valid", int'(oValid), 0);
      chk("hold.ones",  int'(oOnes),  1);
      chk("hold.err",   int'(oErr),   1);
      chk("hold.busy",  int'(oBusy),  0);
      chk("hold.done",  int'(oDone),  0);
    end

    // iStart with coincident iValid: start clears err, sample is dropped
    iStart = 1'b1;
    tick();
    iStart = 1'b0; iValid = 1'b0;
    chk("co.valid", int'(oValid), 0);
    chk("co.err",   int'(oErr),   0);
    chk("co.ones",  int'(oOnes),  0);
    chk("co.busy",  int'(oBusy),  1);
    for (int j = 0; j < 4; j++)
      sendSample($sformatf("co.v%0d", j), 2'd0, 1'b0, 0, 1'b0, j == 3);

    // iStart during RUN is ignored
    startStream();
    sendSample("rs.v0", 2'd2, 1'b1, 1, 1'b0, 1'b0);
    sendSample("rs.v1", 2'd2, 1'b1, 2, 1'b0, 1'b0);
    startStream();
    chk("rs.ones", int'(oOnes), 2);
    chk("rs.busy", int'(oBusy), 1);
    sendSample("rs.v2", 2'd0, 1'b0, 2, 1'b0, 1'b0);
    sendSample("rs.v3", 2'd0, 1'b0, 2, 1'b0, 1'b1);

    // asynchronous reset mid-stream
    startStream();
    sendSample("ar.v0", 2'd2, 1'b1, 1, 1'b0, 1'b0);
    sendSample("ar.v1", 2'd2, 1'b1, 2, 1'b0, 1'b0);
    iValid = 1'b1; iCnt = 2'd2;
    #2 iRstN = 1'b0;
    #1;
    chk("ar.valid", int'(oValid), 0);
    chk("ar.bit",   int'(oBit),   0);
    chk("ar.ones",  int'(oOnes),  0);
    chk("ar.busy",  int'(oBusy),  0);
    chk("ar.done",  int'(oDone),  0);
    tick();
    iRstN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ar.post.valid", int'(oValid), 0);
      chk("ar.post.done",  int'(oDone),  0);
      chk("ar.post.busy",  int'(oBusy),  0);
    end
    iValid = 1'b0;

    // LEN=1 instance
    startStream();
    chk("l1.start.busy", int'(d1Busy), 1);
    iValid = 1'b1; iCnt = 2'd1;
    tick();
    iValid = 1'b0;
    chk("l1.a.valid", int'(d1Valid), 1);
    chk("l1.a.bit",   int'(d1Bit),   0);
    chk("l1.a.done",  int'(d1Done),  1);
    chk("l1.a.ones",  int'(d1Ones),  0);
    chk("l1.a.busy",  int'(d1Busy),  0);
    tick();
    chk("l1.a.pulse", int'(d1Done), 0);
    startStream();
    iValid = 1'b1; iCnt = 2'd2;
    tick();
    iValid = 1'b0;
    chk("l1.b.bit",  int'(d1Bit),  1);
    chk("l1.b.done", int'(d1Done), 1);
    chk("l1.b.ones", int'(d1Ones), 1);
    chk("l1.b.err",  int'(d1Err),  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/usadd_unary_emit.md
Name: usadd_unary_emit

Overview:
- Other end of the parallel counter: consumes the per-cycle binary ones-count produced from NINPUT unary streams and re-serialises it into one scaled unary bitstream (scaled addition, divide by NINPUT).
- Tracks a fixed-length stream of LEN samples through a small FSM and reports the total ones emitted, so the result can be decoded and checked at the end of the stream.
- Sits downstream of the parallel counter inside the uSADD datapath.

Parameters:
- BINPUT, 2, width of the incoming count iCnt.
- NINPUT, 2, number of unary inputs counted; legal iCnt range is 0..NINPUT; also the scale divisor.
- LEN, 256, samples per stream; LEN >= 1.

Ports:
- iClk  input  1  clock, rising edge.
- iRstN  input  1  asynchronous active-low reset.
- iStart  input  1  one-cycle pulse; begins a new stream.
- iValid  input  1  iCnt is valid this cycle.
- iCnt  input  BINPUT  ones-count from the parallel counter.
- oBit  output  1  scaled unary output bit.
- oValid  output  1  oBit is valid this cycle.
- oBusy  output  1  high while in RUN.
- oDone  output  1  one-cycle pulse when the LEN-th sample has been emitted.
- oOnes  output  $clog2(LEN+1)  number of 1s emitted in the current or last stream.
- oErr  output  1  sticky: an out-of-range iCnt was seen this stream.

Behaviour:
- Reset (async, iRstN=0): state=IDLE, acc=0, sample count=0, oBit=0, oValid=0, oBusy=0, oDone=0, oOnes=0, oErr=0. Reset asserted mid-stream aborts the stream immediately; no oDone is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE --iStart--> RUN.
  - RUN --(LEN-th valid sample accepted)--> DONE.
  - DONE --iStart--> RUN; otherwise DONE holds.
- Entering RUN (from IDLE or DONE): acc=0, sample count=0, oOnes=0, oErr=0, all on the clock edge that samples iStart.
- iStart while in RUN is ignored; the stream continues undisturbed.
- iValid in IDLE or DONE is ignored: no output, no state change. iValid in the same cycle as iStart is also ignored; the first sample is taken on the following cycle.
- Per valid sample in RUN:
  - c = min(iCnt, NINPUT). If iCnt > NINPUT, set oErr (sticky until the next iStart).
  - sum = acc + c.
  - If sum >= NINPUT: emit 1, acc <= sum - NINPUT. Otherwise: emit 0, acc <= sum.
  - Invariant: acc stays in 0..NINPUT-1. Accumulator width is $clog2(2*NINPUT).
- Latency: oBit/oValid are registered; a sample accepted at edge k appears during cycle k+1.
- Cycles without iValid: oValid=0, oBit=0, acc and counters hold. Gaps are allowed anywhere in the stream.
- oOnes increments together with each emitted 1. It holds its final value in DONE until the next iStart.
- oDone:
  - High in the same cycle as the oValid of the LEN-th sample; oBusy drops in that cycle.
  - The residual acc is discarded (floor rounding).
- No overflow is possible: oOnes <= LEN by construction.

Decomposition:
- Package usadd_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - a localparam helper for the accumulator width ($clog2(2*NINPUT));
  - a localparam helper for the ones-count width ($clog2(LEN+1)).
- One sub-module, usadd_scale_acc, holds the saturate/add/compare/subtract step and the acc register, with clear and enable inputs. The top level holds the FSM, the sample counter, oOnes and oErr.

Test Plan (NINPUT=2, BINPUT=2, LEN=4 unless noted):
- iStart, then iCnt 1,2,0,1 on consecutive cycles -> oBit 0,1,0,1; oOnes=2; oDone on the 4th oValid; state DONE.
- iStart, then iCnt 2,2,2,2 -> oBit 1,1,1,1, oOnes=4. A second stream of iCnt 0,0,0,0 after a new iStart -> all 0s, oOnes=0, oErr=0.
- iCnt 1, idle 3 cycles, then 1,1,1 -> first oBit 0, then 1,0,1 only on oValid cycles; no output during the gap; oOnes=2.
- iCnt 3 (illegal), then 0,0,0 -> first oBit 1 (saturated to 2), oErr=1 held through DONE; next iStart clears oErr.
- iStart pulsed again after 2 samples -> ignored. iRstN pulled low after 2 samples -> all outputs 0 at once, state IDLE, no oDone.
- LEN=1: iStart, iCnt 1 -> oBit 0, oDone in the same cycle, oOnes=0.
